// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx
//
// PS/2 keyboard receiver. The PS/2 clock and data pins are synchronised,
// and the clock is also glitch-filtered. Each 11-bit frame (start, 8 data
// LSB first, odd parity, stop) is checked. The E0 and F0 prefixes are folded
// into tagged key events, and those events are buffered in a show-ahead FIFO.
//
// Ports:
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   ps2_clk    - PS/2 clock pin (asynchronous)
//   ps2_data   - PS/2 data pin (asynchronous)
//   clear      - one-cycle pulse that zeroes overflow and err_cnt
//   out_valid  - FIFO head holds an event
//   out_ready  - consumer accepts the head event
//   out_code   - scan code of the head event (0 when empty)
//   out_ext    - head event was preceded by E0
//   out_brk    - head event was preceded by F0 (key release)
//   break_cnt  - number of break events generated, modulo 256
//   err_cnt    - number of rejected or abandoned frames, saturating at 255
//   overflow   - sticky: an event was dropped because the FIFO was full
module ps2_keyboard_rx #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clear,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_code,
  output logic       out_ext,
  output logic       out_brk,
  output logic [7:0] break_cnt,
  output logic [7:0] err_cnt,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  // Input synchronisers. Both pins use the same depth so that the data
  // sample stays aligned with the clock edge it belongs to.
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_s;
  logic                   data_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  // Glitch filter. The filtered level flips only after FILTER_LEN
  // consecutive samples disagree with it, so any shorter disagreement is
  // discarded. filt_prev delays the filtered level by one cycle so that a
  // falling edge can be detected.
  logic          filt_clk;
  logic          filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_clk;
      if (clk_s != filt_clk) begin
        if (filt_cnt == FILT_LAST) begin
          filt_clk <= clk_s;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign strobe = filt_prev & ~filt_clk;

  // Frame assembly. Bits shift in from the top. After ten strobes, bit 0
  // holds the start bit, bits 8:1 hold the data byte and bit 9 holds the
  // parity bit. The 11th strobe carries the stop bit, which is checked
  // directly from the live sample.
  logic [3:0]    bit_cnt;
  logic [9:0]    frame_buf;
  logic [TW-1:0] to_cnt;
  logic          frame_done;
  logic          frame_good;
  logic          timeout;
  logic [7:0]    rx_byte;

  assign rx_byte    = frame_buf[8:1];
  assign frame_done = strobe && (bit_cnt == 4'd10);
  assign frame_good = frame_done && !frame_buf[0] && data_s && (^frame_buf[9:1]);
  assign timeout    = (bit_cnt != 4'd0) && !strobe && (to_cnt == TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      frame_buf <= '0;
    end else if (strobe) begin
      if (bit_cnt == 4'd10) begin
        bit_cnt <= '0;
      end else begin
        frame_buf <= {data_s, frame_buf[9:1]};
        bit_cnt   <= bit_cnt + 4'd1;
      end
    end else if (timeout) begin
      bit_cnt <= '0;
    end
  end

  // The idle-time counter runs only inside a partial frame. It restarts on
  // every strobe, so the timeout fires after TIMEOUT_CYCLES quiet cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
    end else if ((bit_cnt == 4'd0) || strobe || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Prefix decoder. E0 and F0 only set flags. Any other good byte becomes
  // an event tagged with the current flags, and then both flags clear.
  logic ext_flag;
  logic brk_flag;
  logic ev_valid;

  assign ev_valid = frame_good && (rx_byte != 8'hE0) && (rx_byte != 8'hF0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (frame_good) begin
      if (rx_byte == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (rx_byte == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // Event FIFO. The head entry is shown directly on the outputs, and a pop
  // takes effect on the handshake edge. A push into a full FIFO succeeds
  // only if a pop frees the slot in the same cycle.
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic [9:0]    head;

  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);
  assign pop   = !empty && out_ready;
  assign wr_en = ev_valid && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {ext_flag, brk_flag, rx_byte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid = !empty;
  assign out_code  = empty ? 8'h00 : head[7:0];
  assign out_brk   = empty ? 1'b0 : head[8];
  assign out_ext   = empty ? 1'b0 : head[9];

  // Status counters. A clear pulse takes priority over a coincident
  // increment or set. break_cnt also counts break events that the FIFO
  // drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt   <= '0;
      overflow  <= 1'b0;
      break_cnt <= '0;
    end else begin
      if (clear) begin
        err_cnt <= '0;
      end else if (((frame_done && !frame_good) || timeout) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (clear) begin
        overflow <= 1'b0;
      end else if (ev_valid && full && !pop) begin
        overflow <= 1'b1;
      end

      if (ev_valid && brk_flag) begin
        break_cnt <= break_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb_ps2_keyboard_rx
//
// Directed testbench for ps2_keyboard_rx. It drives whole PS/2 frames
// through the pins and checks the resulting events and status outputs
// against hand-computed values.
module tb_ps2_keyboard_rx;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 16;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic       out_ext;
  logic       out_brk;
  logic [7:0] break_cnt;
  logic [7:0] err_cnt;
  logic       overflow;

  int compareCount  = 0;
  int mismatchCount = 0;

  ps2_keyboard_rx #(
    .FIFO_DEPTH(DEPTH),
    .SYNC_STAGES(3),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .clear(clear),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_code(out_code),
    .out_ext(out_ext),
    .out_brk(out_brk),
    .break_cnt(break_cnt),
    .err_cnt(err_cnt),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every input change and every output sample happens on the falling edge.
  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // One PS/2 bit. Data changes while the clock is high, and the clock then
  // stays low long enough for the strobe to sample the settled data.
  task automatic sendBit(input logic b);
    ps2_data = b;
    waitCycles(HALF);
    ps2_clk = 1'b0;
    waitCycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Full frame: start, data LSB first, parity (optionally corrupted), stop.
  task automatic applyStimulus(input logic [7:0] code, input logic flipParity,
                               input logic stopBit);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(code[i]);
    sendBit((~^code) ^ flipParity);
    sendBit(stopBit);
    ps2_data = 1'b1;
    waitCycles(2 * HALF);
  endtask

  // Checks the head event, then pops it with a one-cycle ready pulse.
  task automatic expectEvent(input string tag, input logic [7:0] code,
                             input logic ext, input logic brk);
    checkOutput({tag, ".valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, ".code"}, 32'(out_code), 32'(code));
    checkOutput({tag, ".ext"}, 32'(out_ext), 32'(ext));
    checkOutput({tag, ".brk"}, 32'(out_brk), 32'(brk));
    out_ready = 1'b1;
    waitCycles(1);
    out_ready = 1'b0;
  endtask

  logic [7:0] makeCodes [6];

  initial begin
    reset     = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    clear     = 1'b0;
    out_ready = 1'b0;
    makeCodes[0] = 8'h15;
    makeCodes[1] = 8'h16;
    makeCodes[2] = 8'h1D;
    makeCodes[3] = 8'h24;
    makeCodes[4] = 8'h2D;
    makeCodes[5] = 8'h2C;
    waitCycles(5);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] reset state");
    checkOutput("rst.valid", 32'(out_valid), 32'd0);
    checkOutput("rst.code", 32'(out_code), 32'd0);
    checkOutput("rst.brk_cnt", 32'(break_cnt), 32'd0);
    checkOutput("rst.err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst.overflow", 32'(overflow), 32'd0);

    $display("[TB] single make/break");
    applyStimulus(8'h1C, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b0, 1'b1);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    checkOutput("mb.brk_cnt", 32'(break_cnt), 32'd1);
    checkOutput("mb.err_cnt", 32'(err_cnt), 32'd0);
    expectEvent("mb.ev0", 8'h1C, 1'b0, 1'b0);
    expectEvent("mb.ev1", 8'h1C, 1'b0, 1'b1);
    checkOutput("mb.empty", 32'(out_valid), 32'd0);

    $display("[TB] extended key");
    applyStimulus(8'hE0, 1'b0, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b1);
    applyStimulus(8'hE0, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b0, 1'b1);
    applyStimulus(8'h75, 1'b0, 1'b1);
    checkOutput("ext.brk_cnt", 32'(break_cnt), 32'd2);
    expectEvent("ext.ev0", 8'h75, 1'b1, 1'b0);
    expectEvent("ext.ev1", 8'h75, 1'b1, 1'b1);
    checkOutput("ext.empty", 32'(out_valid), 32'd0);

    $display("[TB] errors");
    applyStimulus(8'h1C, 1'b1, 1'b1);
    checkOutput("err.parity", 32'(err_cnt), 32'd1);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    checkOutput("err.stop", 32'(err_cnt), 32'd2);
    ps2_data = 1'b1;
    waitCycles(2 * HALF);
    for (int i = 0; i < 5; i++) sendBit(i == 0 ? 1'b0 : 1'b1);
    ps2_data = 1'b1;
    waitCycles(TIMEOUT + 10);
    checkOutput("err.timeout", 32'(err_cnt), 32'd3);
    checkOutput("err.noevent", 32'(out_valid), 32'd0);
    applyStimulus(8'h1C, 1'b0, 1'b1);
    expectEvent("err.recover", 8'h1C, 1'b0, 1'b0);
    checkOutput("err.empty", 32'(out_valid), 32'd0);

    $display("[TB] overflow");
    for (int i = 0; i < DEPTH + 2; i++) applyStimulus(makeCodes[i], 1'b0, 1'b1);
    checkOutput("ovf.flag", 32'(overflow), 32'd1);
    checkOutput("ovf.valid", 32'(out_valid), 32'd1);
    checkOutput("ovf.hold", 32'(out_code), 32'h15);
    clear = 1'b1;
    waitCycles(1);
    clear = 1'b0;
    checkOutput("ovf.cleared", 32'(overflow), 32'd0);
    checkOutput("ovf.err_clr", 32'(err_cnt), 32'd0);
    checkOutput("ovf.brk_keep", 32'(break_cnt), 32'd2);
    for (int i = 0; i < DEPTH; i++) expectEvent($sformatf("ovf.ev%0d", i), makeCodes[i], 1'b0, 1'b0);
    checkOutput("ovf.drained", 32'(out_valid), 32'd0);
    checkOutput("ovf.code0", 32'(out_code), 32'd0);

    $display("[TB] glitches and reset");
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      waitCycles(1);
      ps2_clk = 1'b1;
      waitCycles(10);
      ps2_clk = 1'b0;
      waitCycles(3);
      ps2_clk = 1'b1;
      waitCycles(10);
    end
    waitCycles(TIMEOUT + 10);
    checkOutput("glitch.err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("glitch.noevent", 32'(out_valid), 32'd0);
    sendBit(1'b0);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    reset = 1'b1;
    waitCycles(3);
    reset = 1'b0;
    ps2_data = 1'b1;
    waitCycles(4);
    checkOutput("rstmid.brk_cnt", 32'(break_cnt), 32'd0);
    checkOutput("rstmid.valid", 32'(out_valid), 32'd0);
    applyStimulus(8'h2A, 1'b0, 1'b1);
    expectEvent("rstmid.ev", 8'h2A, 1'b0, 1'b0);
    checkOutput("rstmid.single", 32'(out_valid), 32'd0);
    checkOutput("rstmid.err_cnt", 32'(err_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
